// File: rtl/n64_pkg.sv
// Shared types and field positions for the N64 controller status reply.
package n64_pkg;

  localparam int N64_RESP_BITS = 32;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EDGE,
    SAMPLE,
    WAIT_HIGH,
    STOP,
    DONE,
    ERROR,
    HOLD
  } rx_state_e;

  localparam int BTN_A     = 31;
  localparam int BTN_B     = 30;
  localparam int BTN_Z     = 29;
  localparam int BTN_START = 28;
  localparam int BTN_DU    = 27;
  localparam int BTN_DD    = 26;
  localparam int BTN_DL    = 25;
  localparam int BTN_DR    = 24;
  localparam int BTN_L     = 21;
  localparam int BTN_R     = 20;
  localparam int BTN_CU    = 19;
  localparam int BTN_CD    = 18;
  localparam int BTN_CL    = 17;
  localparam int BTN_CR    = 16;

  localparam int STICK_X_HI = 15;
  localparam int STICK_X_LO = 8;
  localparam int STICK_Y_HI = 7;
  localparam int STICK_Y_LO = 0;

  function automatic logic [7:0] stick_x(input logic [N64_RESP_BITS-1:0] word);
    return word[STICK_X_HI:STICK_X_LO];
  endfunction

  function automatic logic [7:0] stick_y(input logic [N64_RESP_BITS-1:0] word);
    return word[STICK_Y_HI:STICK_Y_LO];
  endfunction

endpackage

// File: rtl/n64_line_sync.sv
// Two-flop synchronizer for the N64 data line with registered edge flags.
// Flops reset high because the line idles high; edge flags lag the level by one cycle.
module n64_line_sync (
  input  logic clk,
  input  logic Reset,
  input  logic data_i,
  output logic line_o,
  output logic fall_o,
  output logic rise_o
);

  logic sync1_q, sync2_q, prev_q;
  logic fall_q, rise_q;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      fall_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= data_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fall_q  <= prev_q & ~sync2_q;
      rise_q  <= ~prev_q & sync2_q;
    end
  end

  assign line_o = sync2_q;
  assign fall_o = fall_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/n64_response_receiver.sv
// Decodes the 32-bit N64 controller status reply plus stop bit from the data line.
//
// state     | meaning
// IDLE      | disarmed, waiting for Enable_Recieve
// WAIT_EDGE | waiting for the falling edge that starts the next bit
// SAMPLE    | counting to the mid-bit sample point
// WAIT_HIGH | bit sampled, waiting for the line to return high
// STOP      | all bits in, waiting for stop-bit fall then rise
// DONE      | reply good, publish it
// ERROR     | timeout or protocol abort, flag it
// HOLD      | frame finished, wait for enable to drop
module n64_response_receiver
  import n64_pkg::*;
#(
  parameter int SAMPLE_DELAY = 100,
  parameter int TIMEOUT      = 1000,
  parameter int NUM_BITS     = N64_RESP_BITS
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                Enable_Recieve,
  input  logic                Data_In,
  output logic [NUM_BITS-1:0] Controller_Data,
  output logic                Data_Valid,
  output logic                Frame_Error,
  output logic                Busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(NUM_BITS + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [TW-1:0] SDLY = TW'(SAMPLE_DELAY);
  localparam logic [CW-1:0] NBITS = CW'(NUM_BITS);

  logic line, fall, rise;

  n64_line_sync u_sync (
    .clk    (clk),
    .Reset  (Reset),
    .data_i (Data_In),
    .line_o (line),
    .fall_o (fall),
    .rise_o (rise)
  );

  rx_state_e             state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d, timer_inc;
  logic [CW-1:0]         bitcnt_q, bitcnt_d;
  logic [NUM_BITS-1:0]   shift_q, shift_d;
  logic                  stop_fell_q, stop_fell_d;
  logic [NUM_BITS-1:0]   data_q;
  logic                  valid_q, err_q;
  logic                  timeout;

  assign timer_inc = (timer_q == TMAX) ? timer_q : timer_q + 1'b1;
  assign timeout   = (timer_q == TMAX);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_inc;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    stop_fell_d = stop_fell_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (Enable_Recieve) begin
          state_d  = WAIT_EDGE;
          bitcnt_d = '0;
          shift_d  = '0;
        end
      end
      WAIT_EDGE: begin
        // Silence before the first bit just means no controller is plugged in.
        if (fall) begin
          state_d = SAMPLE;
          timer_d = '0;
        end else if (timeout && bitcnt_q != '0) begin
          state_d = ERROR;
        end
      end
      SAMPLE: begin
        if (timer_q == SDLY) begin
          shift_d  = {shift_q[NUM_BITS-2:0], line};
          bitcnt_d = bitcnt_q + 1'b1;
          state_d  = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (line) begin
          state_d     = (bitcnt_q < NBITS) ? WAIT_EDGE : STOP;
          timer_d     = '0;
          stop_fell_d = 1'b0;
        end else if (timeout) begin
          state_d = ERROR;
        end
      end
      STOP: begin
        // The rise flag lags entry into STOP, so only a rise after the stop fall counts.
        if (!stop_fell_q) begin
          if (fall) begin
            stop_fell_d = 1'b1;
            timer_d     = '0;
          end else if (timeout) begin
            state_d = ERROR;
          end
        end else if (rise) begin
          state_d = DONE;
        end else if (timeout) begin
          state_d = ERROR;
        end
      end
      DONE:    state_d = HOLD;
      ERROR:   state_d = HOLD;
      HOLD:    if (!Enable_Recieve) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!Enable_Recieve && state_q != DONE && state_q != ERROR) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      stop_fell_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      stop_fell_q <= stop_fell_d;
      valid_q     <= (state_q == DONE);
      err_q       <= (state_q == ERROR);
      if (state_q == DONE) data_q <= shift_q;
    end
  end

  assign Controller_Data = data_q;
  assign Data_Valid      = valid_q;
  assign Frame_Error     = err_q;
  assign Busy = (state_q == SAMPLE) || (state_q == WAIT_HIGH) || (state_q == STOP) ||
                (state_q == WAIT_EDGE && bitcnt_q != '0);

endmodule

// File: tb/tb_n64_response_receiver.sv
// Directed bench for n64_response_receiver: drives N64-style bit waveforms and checks results.
module tb_n64_response_receiver;
  import n64_pkg::*;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Enable_Recieve = 1'b0;
  logic        Data_In = 1'b1;
  logic [31:0] Controller_Data;
  logic        Data_Valid, Frame_Error, Busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int dv_cnt = 0, fe_cnt = 0, both_cnt = 0;
  int fe_cyc = 0, last_rise_cyc = 0;
  int dv0, fe0;

  n64_response_receiver dut (
    .clk             (clk),
    .Reset           (Reset),
    .Enable_Recieve  (Enable_Recieve),
    .Data_In         (Data_In),
    .Controller_Data (Controller_Data),
    .Data_Valid      (Data_Valid),
    .Frame_Error     (Frame_Error),
    .Busy            (Busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (Data_Valid) dv_cnt++;
    if (Frame_Error) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (Data_Valid && Frame_Error) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    Data_In = 1'b0;
    wait_cyc(b ? 50 : 150);
    Data_In = 1'b1;
    last_rise_cyc = cyc;
    wait_cyc(b ? 150 : 50);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[31-i]);
  endtask

  task automatic send_frame(input logic [31:0] w);
    send_bits(w, 32);
    Data_In = 1'b0;
    wait_cyc(50);
    Data_In = 1'b1;
    wait_cyc(20);
  endtask

  task automatic new_window();
    Enable_Recieve = 1'b0;
    wait_cyc(5);
    Enable_Recieve = 1'b1;
    wait_cyc(5);
  endtask

  initial begin
    wait_cyc(3);
    chk("rst_data", Controller_Data, 32'h0);
    chk("rst_flags", {29'd0, Data_Valid, Frame_Error, Busy}, 32'h0);
    Reset = 1'b1;
    wait_cyc(3);

    // 1: single button bit
    new_window();
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_bits(32'h8000_0000, 3);
    chk("t1_busy_mid", {31'd0, Busy}, 32'd1);
    send_bits(32'h0000_0000, 29);
    Data_In = 1'b0; wait_cyc(50); Data_In = 1'b1; wait_cyc(20);
    chk("t1_dv", dv_cnt - dv0, 1);
    chk("t1_fe", fe_cnt - fe0, 0);
    chk("t1_data", Controller_Data, 32'h8000_0000);
    chk("t1_btn_a", {31'd0, Controller_Data[BTN_A]}, 32'd1);
    chk("t1_busy_end", {31'd0, Busy}, 32'd0);

    // 2: two windows
    new_window();
    dv0 = dv_cnt;
    send_frame(32'h1234_00FF);
    chk("t2_data1", Controller_Data, 32'h1234_00FF);
    chk("t2_stick_x", {24'd0, stick_x(Controller_Data)}, 32'h00);
    chk("t2_stick_y", {24'd0, stick_y(Controller_Data)}, 32'hFF);
    new_window();
    send_frame(32'hFFFF_FFFF);
    chk("t2_data2", Controller_Data, 32'hFFFF_FFFF);
    chk("t2_dv", dv_cnt - dv0, 2);

    // 3: truncated reply times out in WAIT_EDGE
    new_window();
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_bits(32'hABCD_0000, 20);
    wait_cyc(1200);
    chk("t3_fe", fe_cnt - fe0, 1);
    chk("t3_dv", dv_cnt - dv0, 0);
    chk("t3_fe_latency", {31'd0, ((fe_cyc - last_rise_cyc) >= 990 && (fe_cyc - last_rise_cyc) <= 1020)}, 32'd1);
    chk("t3_data_kept", Controller_Data, 32'hFFFF_FFFF);

    // 4: line stuck low mid-bit, then HOLD ignores traffic until enable drops
    new_window();
    fe0 = fe_cnt; dv0 = dv_cnt;
    send_bits(32'hF000_0000, 5);
    Data_In = 1'b0;
    wait_cyc(1500);
    Data_In = 1'b1;
    wait_cyc(10);
    chk("t4_fe", fe_cnt - fe0, 1);
    chk("t4_hold_busy", {31'd0, Busy}, 32'd0);
    send_bits(32'h0000_0000, 3);
    chk("t4_hold_busy2", {31'd0, Busy}, 32'd0);
    chk("t4_no_more", (fe_cnt - fe0) + (dv_cnt - dv0), 1);

    // 5: enable dropped after bit 10, then a clean frame
    new_window();
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_bits(32'hFFC0_0000, 10);
    chk("t5_busy_mid", {31'd0, Busy}, 32'd1);
    Enable_Recieve = 1'b0;
    wait_cyc(2);
    chk("t5_abort_busy", {31'd0, Busy}, 32'd0);
    wait_cyc(20);
    chk("t5_abort_flags", (dv_cnt - dv0) + (fe_cnt - fe0), 0);
    Enable_Recieve = 1'b1;
    wait_cyc(5);
    send_frame(32'h0123_4567);
    chk("t5_data", Controller_Data, 32'h0123_4567);
    chk("t5_dv", dv_cnt - dv0, 1);

    // 6: asynchronous reset during bit 15
    new_window();
    send_bits(32'h0000_0000, 14);
    Data_In = 1'b0;
    wait_cyc(20);
    #2 Reset = 1'b0;
    #1;
    chk("t6_rst_data", Controller_Data, 32'h0);
    chk("t6_rst_flags", {29'd0, Data_Valid, Frame_Error, Busy}, 32'h0);
    Data_In = 1'b1;
    wait_cyc(5);
    #2 Reset = 1'b1;
    dv0 = dv_cnt;
    new_window();
    send_frame(32'hA5A5_5A5A);
    chk("t6_data", Controller_Data, 32'hA5A5_5A5A);
    chk("t6_dv", dv_cnt - dv0, 1);

    chk("never_both", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
